// File: rtl/dcache_pkg.sv
// Purpose: shared types and default geometry for the direct-mapped data cache controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dcache_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_MISS = 2'd1,
      WR_THRU = 2'd2
   } state_t;

   localparam int DEF_BUS_WIDTH = 32;
   localparam int DEF_LINES     = 16;
   localparam int DEF_IDX_W     = $clog2(DEF_LINES);
   localparam int DEF_TAG_W     = DEF_BUS_WIDTH - DEF_IDX_W - 2;

   // Tag width left after removing the byte offset and the line index.
   function automatic int tag_w(input int bus_width, input int lines);
      return bus_width - $clog2(lines) - 2;
   endfunction

endpackage

// File: rtl/dcache_array.sv
// Purpose: tag/valid/data storage, one combinational read port and one write port.
// Latency: read is combinational; write lands at the rising edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
// Ports: clk/rst (sync, active-high, clears valid bits only); rd_idx -> rd_vld/rd_tag/rd_data;
//        wr_en/wr_idx/wr_tag/wr_data write a whole line and mark it valid.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int LINES  = DEF_LINES,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DATA_W = DEF_BUS_WIDTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [$clog2(LINES)-1:0] rd_idx,
   output logic                     rd_vld,
   output logic [TAG_W-1:0]         rd_tag,
   output logic [DATA_W-1:0]        rd_data,
   input  logic                     wr_en,
   input  logic [$clog2(LINES)-1:0] wr_idx,
   input  logic [TAG_W-1:0]         wr_tag,
   input  logic [DATA_W-1:0]        wr_data
);

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
      end
   end

   // Tags and data are never reset; an invalid line is ignored regardless of content.
   // A write coinciding with reset is dropped so an abandoned fill leaves no trace.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         tag_mem[wr_idx]  <= wr_tag;
         data_mem[wr_idx] <= wr_data;
      end
   end

   assign rd_vld  = valid[rd_idx];
   assign rd_tag  = tag_mem[rd_idx];
   assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Purpose: direct-mapped, one-word-line data cache; read-allocate, write-through/no-write-allocate.
// Latency: read hit 0 cycles; read miss stalls k+1 cycles; store stalls k+1 then one retire cycle.
// Backpressure: o_stall holds the core; memory side holds its request until i_mem_ack.
// Ports: i_clk/i_rst; core side i_req/i_we/i_addr/i_wdata -> o_rdata/o_stall;
//        memory side o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata <- i_mem_ack/i_mem_rdata;
//        o_hit_cnt/o_miss_cnt saturating read statistics.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int BUS_WIDTH = DEF_BUS_WIDTH,
   parameter int LINES     = DEF_LINES
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_req,
   input  logic                 i_we,
   input  logic [BUS_WIDTH-1:0] i_addr,
   input  logic [BUS_WIDTH-1:0] i_wdata,
   output logic [BUS_WIDTH-1:0] o_rdata,
   output logic                 o_stall,
   output logic                 o_mem_req,
   output logic                 o_mem_we,
   output logic [BUS_WIDTH-1:0] o_mem_addr,
   output logic [BUS_WIDTH-1:0] o_mem_wdata,
   input  logic                 i_mem_ack,
   input  logic [BUS_WIDTH-1:0] i_mem_rdata,
   output logic [31:0]          o_hit_cnt,
   output logic [31:0]          o_miss_cnt
);

   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = tag_w(BUS_WIDTH, LINES);

   state_t               state, state_nxt;
   logic                 retry;      // first IDLE cycle after a fill: held read is not a new hit
   logic                 wr_done;    // first IDLE cycle after a store: let the core retire it
   logic [IDX_W-1:0]     arr_idx;
   logic [TAG_W-1:0]     cmp_tag;
   logic                 line_vld;
   logic [TAG_W-1:0]     line_tag;
   logic [BUS_WIDTH-1:0] line_data;
   logic                 tag_hit;
   logic                 arr_we;
   logic [BUS_WIDTH-1:0] arr_wdata;
   logic                 start_rd, start_wr, count_hit;
   logic                 unused_addr_lo;

   assign unused_addr_lo = &{1'b0, i_addr[1:0]};

   // In IDLE the single read port looks up the live core address; while a memory
   // transaction is open it looks up the registered one, which the store-hit update needs.
   assign arr_idx = (state == IDLE) ? i_addr[IDX_W+1:2] : o_mem_addr[IDX_W+1:2];
   assign cmp_tag = (state == IDLE) ? i_addr[BUS_WIDTH-1:IDX_W+2]
                                    : o_mem_addr[BUS_WIDTH-1:IDX_W+2];
   assign tag_hit = line_vld && (line_tag == cmp_tag);

   dcache_array #(
      .LINES  (LINES),
      .TAG_W  (TAG_W),
      .DATA_W (BUS_WIDTH)
   ) u_array (
      .clk     (i_clk),
      .rst     (i_rst),
      .rd_idx  (arr_idx),
      .rd_vld  (line_vld),
      .rd_tag  (line_tag),
      .rd_data (line_data),
      .wr_en   (arr_we),
      .wr_idx  (o_mem_addr[IDX_W+1:2]),
      .wr_tag  (o_mem_addr[BUS_WIDTH-1:IDX_W+2]),
      .wr_data (arr_wdata)
   );

   always_comb begin
      state_nxt = state;
      o_stall   = 1'b0;
      o_rdata   = '0;
      start_rd  = 1'b0;
      start_wr  = 1'b0;
      count_hit = 1'b0;
      arr_we    = 1'b0;
      arr_wdata = i_mem_rdata;
      case (state)
         IDLE: begin
            if (i_req && !wr_done) begin
               if (i_we) begin
                  o_stall   = 1'b1;
                  start_wr  = 1'b1;
                  state_nxt = WR_THRU;
               end else if (tag_hit) begin
                  o_rdata   = line_data;
                  count_hit = !retry;
               end else begin
                  o_stall   = 1'b1;
                  start_rd  = 1'b1;
                  state_nxt = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            o_stall = 1'b1;
            if (i_mem_ack) begin
               arr_we    = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_THRU: begin
            o_stall = 1'b1;
            if (i_mem_ack) begin
               arr_we    = tag_hit;      // no-write-allocate: only refresh a resident line
               arr_wdata = o_mem_wdata;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         retry       <= 1'b0;
         wr_done     <= 1'b0;
         o_hit_cnt   <= '0;
         o_miss_cnt  <= '0;
      end else begin
         retry   <= (state == RD_MISS) && i_mem_ack;
         wr_done <= (state == WR_THRU) && i_mem_ack;
         if (start_rd || start_wr) begin
            o_mem_req   <= 1'b1;
            o_mem_we    <= start_wr;
            o_mem_addr  <= {i_addr[BUS_WIDTH-1:2], 2'b00};
            o_mem_wdata <= i_wdata;
         end else if (o_mem_req && i_mem_ack) begin
            o_mem_req <= 1'b0;
            o_mem_we  <= 1'b0;
         end
         if (count_hit && (o_hit_cnt != 32'hFFFF_FFFF)) begin
            o_hit_cnt <= o_hit_cnt + 32'd1;
         end
         if (start_rd && (o_miss_cnt != 32'hFFFF_FFFF)) begin
            o_miss_cnt <= o_miss_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Purpose: self-checking bench for dcache_ctrl with a memory responder and reference model.
// Latency: n/a.
// Backpressure: responder acks the k-th o_mem_req cycle, k chosen per transaction.
module tb_dcache_ctrl;

   localparam int LINES = 16;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic        i_req;
   logic        i_we;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic [31:0] o_rdata;
   logic        o_stall;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [31:0] o_mem_addr;
   logic [31:0] o_mem_wdata;
   logic        i_mem_ack;
   logic [31:0] i_mem_rdata;
   logic [31:0] o_hit_cnt;
   logic [31:0] o_miss_cnt;

   always #5 i_clk = ~i_clk;

   dcache_ctrl #(.BUS_WIDTH(32), .LINES(LINES)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_req       (i_req),
      .i_we        (i_we),
      .i_addr      (i_addr),
      .i_wdata     (i_wdata),
      .o_rdata     (o_rdata),
      .o_stall     (o_stall),
      .o_mem_req   (o_mem_req),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_ack   (i_mem_ack),
      .i_mem_rdata (i_mem_rdata),
      .o_hit_cnt   (o_hit_cnt),
      .o_miss_cnt  (o_miss_cnt)
   );

   typedef struct {
      logic [31:0] data;
      int          stalls;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          hits_m = 0;
   int          miss_m = 0;
   logic [31:0] mem_m [logic [31:0]];
   bit          cv_m [LINES];
   logic [31:0] ca_m [LINES];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] wa);
      if (mem_m.exists(wa)) return mem_m[wa];
      return (wa ^ 32'h5A5A_0000) + 32'h1;
   endfunction

   task automatic check_cnts(input string tag);
      check({tag, "_hit_cnt"}, o_hit_cnt, hits_m);
      check({tag, "_miss_cnt"}, o_miss_cnt, miss_m);
   endtask

   // Entered just after a falling edge; returns just after the falling edge that follows retirement.
   task automatic do_read(input logic [31:0] a, input int lat);
      logic [31:0] wa;
      int          ix, stalls, kcnt;
      bit          done;
      exp_t        e, exp_e;
      wa = {a[31:2], 2'b00};
      ix = int'(a[5:2]);
      e.data = mem_val(wa);
      if (cv_m[ix] && ca_m[ix] == wa) begin
         e.stalls = 0;
         hits_m++;
      end else begin
         e.stalls = lat + 1;
         miss_m++;
         cv_m[ix] = 1'b1;
         ca_m[ix] = wa;
      end
      sb_q.push_back(e);
      i_req = 1'b1; i_we = 1'b0; i_addr = a; i_wdata = $urandom;
      stalls = 0; kcnt = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         i_mem_ack = 1'b0;
         if (!o_stall) begin
            exp_e = sb_q.pop_front();
            check("rd_data", o_rdata, exp_e.data);
            check("rd_stalls", stalls, exp_e.stalls);
            done = 1'b1;
         end else begin
            if (stalls == 0) check("rd_miss_rdata_zero", o_rdata, 32'h0);
            stalls++;
            if (o_mem_req) begin
               kcnt++;
               if (kcnt == 1) begin
                  check("rd_mem_addr", o_mem_addr, wa);
                  check("rd_mem_we", o_mem_we, 1'b0);
               end
               i_mem_ack   = (kcnt == lat);
               i_mem_rdata = mem_val(o_mem_addr);
            end
         end
         @(negedge i_clk);
      end
      if (!done) begin
         check("rd_timeout", 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      i_req = 1'b0; i_mem_ack = 1'b0;
      check_cnts("rd");
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat);
      logic [31:0] wa;
      int          stalls, kcnt, we_cyc;
      bit          done;
      exp_t        e, exp_e;
      wa = {a[31:2], 2'b00};
      e.data = d;
      e.stalls = lat + 1;
      sb_q.push_back(e);
      i_req = 1'b1; i_we = 1'b1; i_addr = a; i_wdata = d;
      stalls = 0; kcnt = 0; we_cyc = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         i_mem_ack = 1'b0;
         if (!o_stall) begin
            exp_e = sb_q.pop_front();
            check("wr_stalls", stalls, exp_e.stalls);
            check("wr_we_cycles", we_cyc, lat);
            done = 1'b1;
         end else begin
            stalls++;
            if (o_mem_req) begin
               kcnt++;
               if (o_mem_we) we_cyc++;
               if (kcnt == 1) begin
                  check("wr_mem_addr", o_mem_addr, wa);
                  check("wr_mem_wdata", o_mem_wdata, exp_e.data === 32'hx ? d : d);
               end
               i_mem_ack = (kcnt == lat);
            end
         end
         @(negedge i_clk);
      end
      if (!done) begin
         check("wr_timeout", 32'd0, 32'd1);
         void'(sb_q.pop_front());
      end
      mem_m[wa] = d;
      i_req = 1'b0; i_we = 1'b0; i_mem_ack = 1'b0;
      #1;
      check("wr_no_reissue", o_mem_req, 1'b0);
      @(negedge i_clk);
      check_cnts("wr");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < LINES; i++) cv_m[i] = 1'b0;
      i_rst = 1'b1; i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_wdata = '0;
      i_mem_ack = 1'b0; i_mem_rdata = '0;
      repeat (2) @(negedge i_clk);
      #1;
      check("rst_mem_req", o_mem_req, 1'b0);
      check("rst_mem_we", o_mem_we, 1'b0);
      check("rst_mem_addr", o_mem_addr, 32'h0);
      check("rst_mem_wdata", o_mem_wdata, 32'h0);
      check_cnts("rst");
      i_rst = 1'b0;
      @(negedge i_clk);
      #1;
      check("rst_idle_stall", o_stall, 1'b0);
      check("rst_idle_rdata", o_rdata, 32'h0);
      @(negedge i_clk);

      do_read(32'h40, 1);                  // cold miss, 2 stall cycles
      do_read(32'h40, 1);                  // zero-cycle hit
      do_read(32'h80, 2);                  // same index, evicts 0x40
      do_read(32'h40, 1);                  // misses again
      do_read(32'h43, 1);                  // byte offset ignored
      do_read(32'h44, 3);                  // other index
      do_write(32'h40, 32'hDEAD_BEEF, 3);  // store hit, updates line
      do_read(32'h40, 1);                  // hits with stored value
      do_write(32'h100, 32'h1234_5678, 2); // store miss, no allocate
      do_read(32'h40, 1);                  // still resident and unchanged
      do_read(32'h100, 1);                 // must miss
      do_read(32'h44, 1);                  // still a hit

      // Reset in the second RD_MISS cycle, then a stray late ack.
      i_req = 1'b1; i_we = 1'b0; i_addr = 32'h200;
      #1;
      check("abort_first_stall", o_stall, 1'b1);
      @(negedge i_clk); #1;
      check("abort_rdmiss_req", o_mem_req, 1'b1);
      @(negedge i_clk); #1;
      i_rst = 1'b1;
      @(negedge i_clk); #1;
      check("abort_mem_req", o_mem_req, 1'b0);
      i_rst = 1'b0; i_req = 1'b0;
      #1;
      check("abort_stall", o_stall, 1'b0);
      i_mem_ack = 1'b1;
      @(negedge i_clk); #1;
      i_mem_ack = 1'b0;
      check("late_ack_mem_req", o_mem_req, 1'b0);
      check("late_ack_stall", o_stall, 1'b0);
      for (int i = 0; i < LINES; i++) cv_m[i] = 1'b0;
      hits_m = 0; miss_m = 0;
      check_cnts("abort");
      @(negedge i_clk);
      do_read(32'h40, 1);                  // all lines invalidated
      do_read(32'h44, 2);
      do_read(32'h200, 1);                 // abandoned fill left nothing behind
      do_read(32'h40, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have parameter BUS_WIDTH, default 32, meaning the data and address width.
REQ-002 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped one-word lines (power of two, at least 2).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, stated exactly so: i_clk input 1 (the single clock, rising edge); i_rst input 1 (reset, synchronous, active-high).
REQ-004 The block SHALL have these core-side ports:
- i_req input 1: core load/store request valid.
- i_we input 1: request is a store.
- i_addr input BUS_WIDTH: byte address from the ALU result.
- i_wdata input BUS_WIDTH: store data.
- o_rdata output BUS_WIDTH: load data.
- o_stall output 1: core must hold PC and request.
REQ-005 The block SHALL have these memory-side ports:
- o_mem_req output 1: memory transaction valid.
- o_mem_we output 1: transaction is a write.
- o_mem_addr output BUS_WIDTH: word-aligned address.
- o_mem_wdata output BUS_WIDTH: write data.
- i_mem_ack input 1: transaction complete.
- i_mem_rdata input BUS_WIDTH: read data, valid with ack.
REQ-006 The block SHALL have these counter outputs:
- o_hit_cnt output 32: read hits.
- o_miss_cnt output 32: read misses.

Function
REQ-007 Address split SHALL be: addr[1:0] ignored; index = addr[IDX+1:2] with IDX = log2(LINES); tag = the remaining upper bits.
REQ-008 The FSM SHALL have three states: IDLE, RD_MISS and WR_THRU.
REQ-009 In IDLE, a read with a valid line and a matching tag SHALL return o_rdata = line data combinationally, with o_stall = 0 (zero-cycle hit).
REQ-010 In IDLE, a read miss SHALL assert o_stall combinationally in that cycle and move to RD_MISS at the next edge.
REQ-011 In IDLE, any write SHALL assert o_stall combinationally and move to WR_THRU at the next edge.
REQ-012 o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata SHALL be registered, driven from the cycle the FSM enters RD_MISS or WR_THRU, and held stable until i_mem_ack is sampled high.
REQ-013 o_mem_addr SHALL equal {i_addr[BUS_WIDTH-1:2], 2'b00}.
REQ-014 On the ack edge in RD_MISS, the block SHALL write the line (valid = 1, tag, i_mem_rdata) and return to IDLE; the held request then hits with o_stall = 0.
REQ-015 Read-miss stall cycles SHALL equal k+1, where k ≥ 1 is the o_mem_req cycle in which ack arrives.
REQ-016 Writes SHALL be write-through, no-write-allocate: on the ack edge in WR_THRU, a tag-hit line's data SHALL be updated, a miss SHALL leave the array unchanged, and the FSM SHALL return to IDLE.
REQ-017 After a write returns to IDLE, the block SHALL deassert o_stall for exactly one cycle so the core retires the store rather than re-issuing it.
REQ-018 While o_stall = 1, the core SHALL hold i_req, i_we, i_addr and i_wdata stable; the block SHALL use request values registered at IDLE exit.
REQ-019 i_mem_ack SHALL be ignored whenever o_mem_req = 0.
REQ-020 o_rdata SHALL be 0 when there is no read hit.
REQ-021 o_hit_cnt SHALL increment once per completed read that hits in IDLE on first presentation; o_miss_cnt SHALL increment once per RD_MISS entry.
REQ-022 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-023 A retried read after a fill SHALL NOT count as a hit.
REQ-024 An outstanding memory transaction SHALL complete even if i_req drops.

Reset
REQ-025 On i_rst at a rising edge: state = IDLE, all valid bits = 0, o_mem_req = 0, o_mem_we = 0, o_mem_addr = 0, o_mem_wdata = 0, counters = 0.
REQ-026 After reset, o_stall SHALL be 0 while i_req = 0.
REQ-027 Reset during RD_MISS or WR_THRU SHALL abandon the transaction and deassert o_mem_req at that edge; no line SHALL be written.
REQ-028 Tag and data storage SHALL not be reset; only the valid bits are.

Structure
REQ-029 Package dcache_pkg SHALL hold the state enum, the LINES default and the derived IDX/TAG widths.
REQ-030 Tag/valid/data storage SHALL be a sub-module named dcache_array: one read port, one write port, valid-clear on reset.

Verification
REQ-031 Reset, then read 0x40 with ack at k=1 -> o_stall high for 2 cycles; o_mem_addr = 0x40; fill; o_rdata = mem value; o_miss_cnt = 1.
REQ-032 Re-read 0x40 -> o_stall = 0 in the same cycle; o_rdata = cached value; o_hit_cnt = 1.
REQ-033 Read 0x80 (same index, LINES=16) then 0x40 -> both miss, and 0x80 evicts 0x40.
REQ-034 Write 0x40 = 0xDEADBEEF with a 3-cycle ack -> o_mem_we = 1 held 3 cycles; then read 0x40 hits with 0xDEADBEEF; write to unallocated 0x100 leaves 0x100 missing.
REQ-035 Reset asserted in the 2nd RD_MISS cycle -> o_mem_req = 0 next cycle; all lines invalid; late ack ignored.
REQ-036 Address 0x43 -> behaves identically to 0x40.
